// File: rtl/idu_pipe.sv
`default_nettype none
// ============================================================================
// Module : idu_pipe
// Brief  : Registered RV32I decode stage with a two-entry main/skid buffer.
//          Optional macro IDU_ILLEGAL_EN enables illegal-encoding detection.
// Rev    : 1.0 - initial release
// ============================================================================
module idu_pipe #(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ILEN-1:0]   in_inst,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic              out_rd_en,
  output logic              out_rs1_en,
  output logic              out_rs2_en,
  output logic [XLEN-1:0]   out_imm,
  output logic [9:0]        out_fun,
  output logic [5:0]        out_type,
  output logic              out_illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rd_en;
    logic              rs1_en;
    logic              rs2_en;
    logic [XLEN-1:0]   imm;
    logic [9:0]        fun;
    logic [5:0]        typ;
    logic              illegal;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  entry_t dec;
  logic   in_fire, out_fire;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic               is_shift;
  logic               is_r, is_i, is_s, is_b, is_u, is_j;
  logic signed [31:0] imm32;

  always_comb begin
    opcode   = in_inst[6:0];
    funct3   = in_inst[14:12];
    funct7   = in_inst[31:25];
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_IMM) || (opcode == OP_LOAD) ||
               (opcode == OP_JALR) || (opcode == OP_SYS);
    is_s     = (opcode == OP_STORE);
    is_b     = (opcode == OP_BR);
    is_u     = (opcode == OP_LUI) || (opcode == OP_AUIPC);
    is_j     = (opcode == OP_JAL);
    is_shift = (opcode == OP_IMM) && (funct3[1:0] == 2'b01);

    imm32 = '0;
    if (is_shift)
      imm32 = {27'b0, in_inst[24:20]};
    else if (is_i)
      imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
    else if (is_s)
      imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    else if (is_b)
      imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    else if (is_u)
      imm32 = {in_inst[31:12], 12'b0};
    else if (is_j)
      imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    dec         = '0;
    dec.pc      = in_pc;
    dec.rd      = REG_AW'(in_inst[11:7]);
    dec.rs1     = REG_AW'(in_inst[19:15]);
    dec.rs2     = REG_AW'(in_inst[24:20]);
    dec.typ     = {is_r, is_i, is_s, is_b, is_u, is_j};
    dec.rd_en   = (is_r || is_i || is_u || is_j) && (in_inst[11:7] != 5'd0);
    dec.rs1_en  = is_r || is_i || is_s || is_b;
    dec.rs2_en  = is_r || is_s || is_b;
    dec.imm     = XLEN'(imm32);
    // Unknown opcodes pass the raw funct7 through along with R and shift-immediates.
    dec.fun     = {funct3, (is_r || is_shift || (dec.typ == 6'd0)) ? funct7 : 7'b0};
`ifdef IDU_ILLEGAL_EN
    dec.illegal = (dec.typ == 6'd0) || (in_inst[1:0] != 2'b11) ||
                  (is_r && (funct7 != 7'b0000000) && (funct7 != 7'b0100000)) ||
                  (is_shift && (funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                  (is_shift && (funct3 == 3'b101) &&
                   (funct7 != 7'b0000000) && (funct7 != 7'b0100000));
`else
    dec.illegal = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_fire  = in_valid && in_ready_q;
    out_fire = (state_q != S_EMPTY) && out_ready;

    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            main_d  = dec;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = dec;
          end else if (in_fire) begin
            skid_d  = dec;
            state_d = S_TWO;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != S_EMPTY);
  assign out_pc      = main_q.pc;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd_en   = main_q.rd_en;
  assign out_rs1_en  = main_q.rs1_en;
  assign out_rs2_en  = main_q.rs2_en;
  assign out_imm     = main_q.imm;
  assign out_fun     = main_q.fun;
  assign out_type    = main_q.typ;
  assign out_illegal = main_q.illegal;

endmodule
`default_nettype wire
